// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC controller and its atan ROM.
// The atan table is computed at elaboration using integer fixed-point arithmetic only.
package cordic_pkg;

   typedef enum logic [1:0] {StIdle, StIter, StDone} cordic_state_t;

   localparam logic MODE_ROT = 1'b1;
   localparam logic MODE_VEC = 1'b0;

   localparam int unsigned ATAN_ENTRIES = 32;
   localparam int unsigned ATAN_IDX_W   = 5;
   localparam int          FRAC_BITS    = 60;
   // pi with FRAC_BITS fractional bits
   localparam logic [127:0] PI_FX = 128'h3243F6A8885A308D;

   typedef logic [ATAN_ENTRIES-1:0][31:0] atan_tab_t;

   // atan(2^-i) by its Taylor series, then rescaled so that pi maps to 2^(width-1), rounded.
   function automatic atan_tab_t atan_table(input int unsigned width);
      atan_tab_t    tab;
      logic [127:0] acc;
      logic [127:0] term;
      logic [127:0] num;
      int           sh;
      tab = '0;
      for (int i = 0; i < ATAN_ENTRIES; i++) begin
         if (i == 0) begin
            acc = PI_FX >> 2;
         end else begin
            acc = '0;
            for (int k = 0; k < 32; k++) begin
               sh = FRAC_BITS - i * (2 * k + 1);
               if (sh < 0) break;
               term = (128'd1 << sh) / 128'(2 * k + 1);
               if (k % 2 == 0) acc = acc + term;
               else            acc = acc - term;
            end
         end
         num = (acc << (width - 1)) + (PI_FX >> 1);
         tab[i[4:0]] = 32'(num / PI_FX);
      end
      return tab;
   endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table, atan(2^-idx) scaled so that pi = 2^(WIDTH-1).
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 4
) (
   input  logic [CNT_W-1:0] idx,
   output logic [WIDTH-1:0] atan_const
);

   localparam atan_tab_t TABLE = atan_table(WIDTH);

   logic [ATAN_IDX_W-1:0] idx_ext;

   assign idx_ext    = ATAN_IDX_W'(idx);
   assign atan_const = TABLE[idx_ext][WIDTH-1:0];

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Sequencer for a single-stage iterative CORDIC datapath: accepts a job, steps the shared
// micro-rotation stage NUM_STAGES times, then flags the result as final.
module cordic_iter_ctrl
   import cordic_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 12,
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned CNT_W      = $clog2(NUM_STAGES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic             mode,
   output logic             ready_in,
   output logic             load_en,
   output logic             iter_en,
   output logic [CNT_W-1:0] stage_idx,
   output logic [CNT_W-1:0] shift_amt,
   output logic [WIDTH-1:0] atan_const,
   input  logic             z_sign,
   input  logic             y_sign,
   output logic             dir,
   output logic             mode_q,
   output logic             busy,
   output logic             valid_out
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_STAGES - 1);

   cordic_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         mode_q  <= MODE_ROT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      ready_in  = 1'b0;
      load_en   = 1'b0;
      iter_en   = 1'b0;
      busy      = 1'b0;
      valid_out = 1'b0;
      unique case (state_q)
         StIdle: begin
            ready_in = 1'b1;
            if (valid_in) begin
               load_en = 1'b1;
               mode_d  = mode;
               cnt_d   = '0;
               state_d = StIter;
            end
         end
         StIter: begin
            iter_en = 1'b1;
            busy    = 1'b1;
            if (cnt_q == LAST_IDX) begin
               // Park the counter on stage 0 so idle outputs match the reset view.
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            valid_out = 1'b1;
            ready_in  = 1'b1;
            if (valid_in) begin
               load_en = 1'b1;
               mode_d  = mode;
               cnt_d   = '0;
               state_d = StIter;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Rotation drives the residual angle to zero; vectoring drives y to zero.
   always_comb begin
      dir = 1'b0;
      if (iter_en) begin
         case (mode_q)
            MODE_ROT: dir = ~z_sign;
            MODE_VEC: dir = y_sign;
            default:  dir = 1'b0;
         endcase
      end
   end

   assign stage_idx = cnt_q;
   assign shift_amt = cnt_q;

   cordic_atan_rom #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_atan_rom (
      .idx        (cnt_q),
      .atan_const (atan_const)
   );

endmodule

// File: doc/cordic_iter_ctrl.md
# cordic_iter_ctrl

Sequencing controller for the iterative (single-stage) CORDIC datapath. It accepts one angle/vector job per valid handshake and drives the shared micro-rotation stage for `NUM_STAGES` consecutive cycles. On each cycle it supplies the stage index, shift amount, arctangent constant and rotation direction, then pulses `valid_out` when the result registers hold the final `cos`/`sin` (or magnitude/angle). It sits between the job source and the single-stage datapath, which owns the x/y/z registers and adders.

## Interface
Parameters:
- `NUM_STAGES`, 12: number of micro-rotations per job (2..WIDTH).
- `WIDTH`, 16: angle and constant width; angle format is signed, π rad = 2^(WIDTH-1).
- `CNT_W`, $clog2(NUM_STAGES): stage counter width (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: job request.
- `mode` in 1: 1 = rotation, 0 = vectoring; sampled at acceptance.
- `ready_in` out 1: job can be accepted this cycle.
- `load_en` out 1: datapath captures x/y/z inputs at this edge.
- `iter_en` out 1: datapath performs one micro-rotation at this edge.
- `stage_idx` out CNT_W: current micro-rotation index.
- `shift_amt` out CNT_W: shift for x/y cross terms, equal to `stage_idx`.
- `atan_const` out WIDTH: atan(2^-stage_idx) in the angle format.
- `z_sign` in 1: MSB of the datapath residual angle.
- `y_sign` in 1: MSB of the datapath y register.
- `dir` out 1: 1 = positive (counter-clockwise) rotation.
- `mode_q` out 1: latched mode of the job in flight.
- `busy` out 1: job in flight.
- `valid_out` out 1: one-cycle pulse; datapath results are final.

## Operation
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - `ready_in`=1.
  - On `valid_in`: assert `load_en` combinationally, latch `mode_q`, clear the counter, go to ITER.
- ITER:
  - `iter_en`=1 and `busy`=1.
  - The counter increments from 0 to NUM_STAGES-1; on the cycle it reaches NUM_STAGES-1, go to DONE.
- DONE:
  - `valid_out`=1 for exactly one cycle and `ready_in`=1.
  - If `valid_in` is high, accept it as in IDLE and go to ITER (back-to-back); otherwise go to IDLE.
- `valid_in` while in ITER is ignored. There is no queue, and the source must hold or retry.
- `dir`, combinational, meaningful only while `iter_en`=1:
  - rotation mode: `dir` = ~`z_sign` (drive z toward 0);
  - vectoring mode: `dir` = `y_sign` (drive y toward 0).
- `atan_const` = round(atan(2^-i)·2^(WIDTH-1)/π). For WIDTH=16 the first entries are:
  - i=0: 8192
  - i=1: 4836
  - i=2: 2555
  - i=3: 1297
- Entries beyond NUM_STAGES-1 are never addressed.
- Quadrant pre-rotation and gain compensation are out of scope; both are handled by the datapath or upstream.

## Timing
- Reset values: state IDLE, counter 0, `mode_q`=1, and `ready_in`=1. All other outputs are 0, except `atan_const`, which is the stage-0 constant (8192 for WIDTH=16).
- Latency: a job accepted at edge k gives `iter_en` high for the cycles between edges k+1 and k+NUM_STAGES. `valid_out` is high in the following cycle (edge k+NUM_STAGES+1). For NUM_STAGES=12 that is 13 cycles.
- Throughput: one job per NUM_STAGES+1 cycles with back-to-back acceptance in DONE.
- `load_en` and `iter_en` are never high in the same cycle.
- Reset asserted mid-ITER:
  - immediate return to IDLE, with `iter_en`, `busy` and `valid_out` low asynchronously;
  - the job is dropped and no `valid_out` follows.
- `stage_idx`, `atan_const` and `mode_q` are stable for the whole cycle (registered or ROM-from-register; no glitch path from `valid_in`).

## Structure
- Shared package `cordic_pkg` holds:
  - the FSM state enum;
  - mode encoding constants (MODE_ROT=1, MODE_VEC=0);
  - a constant function that builds the atan table for a given WIDTH.
- One sub-module, `cordic_atan_rom`, a combinational table indexed by `stage_idx`. It is reused by the unrolled pipeline variant.

## Test plan
- Single rotation job at NUM_STAGES=12, WIDTH=16, `valid_in` pulsed for one cycle:
  - `load_en` high for 1 cycle, then 12 `iter_en` cycles with `stage_idx` 0..11;
  - `atan_const` 8192, 4836, 2555, 1297, …;
  - `valid_out` 13 cycles after acceptance, with `busy` high only during ITER.
- Direction, with `mode`=1 and `z_sign` toggled each cycle: `dir` = ~`z_sign` every ITER cycle. Repeat with `mode`=0: `dir` = `y_sign`, and `mode_q`=0 throughout.
- Back-to-back: hold `valid_in`=1 continuously. Jobs are accepted in DONE, `valid_out` pulses every 13 cycles, and IDLE is never entered.
- `valid_in` pulsed at ITER stage 5: ignored, with no counter disturbance and exactly one `valid_out` for the first job.
- `rst_n` low at stage 7: outputs immediately return to their reset values, and there is no `valid_out`. After release, a new job completes normally in 13 cycles.
- Sweep of 360 angles (0° to 359°) through controller plus datapath:
  - exactly 360 `valid_out` pulses;
  - results match the fixed-point reference model within ±2 LSB.
